// File: rtl/prng_arb_pkg.sv
// Shared types and constants for the PRNG session arbiter.
package prng_arb_pkg;

  // Session state of the shared PRNG.
  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_SEED = 2'd1,
    STREAM    = 2'd2,
    DRAIN     = 2'd3
  } arb_state_t;

  // Default widths.
  localparam int ARB_NREQ   = 3;
  localparam int ARB_SEED_W = 256;
  localparam int ARB_DATA_W = 128;

  // Session word counter width and its saturation value.
  localparam int              WORDS_W   = 16;
  localparam logic [WORDS_W-1:0] WORDS_MAX = '1;

  // Requester slots.
  localparam int REQ_SB    = 0;
  localparam int REQ_GA    = 1;
  localparam int REQ_SPARE = 2;

  // Wrap an index that may have run at most one lap past n.
  function automatic int rr_wrap(input int v, input int n);
    return (v >= n) ? (v - n) : v;
  endfunction

endpackage

// File: rtl/prng_rr_pick.sv
// Combinational round-robin picker: the first requester found when
// searching upward from last+1 (wrapping) wins. Output is one-hot plus index.
module prng_rr_pick
  import prng_arb_pkg::*;
#(
  parameter int NREQ  = ARB_NREQ,
  parameter int IDX_W = $clog2(NREQ)
) (
  input  logic [NREQ-1:0]  req,
  input  logic [IDX_W-1:0] last,
  output logic [NREQ-1:0]  onehot,
  output logic [IDX_W-1:0] idx,
  output logic             found
);

  // cand[k] is the requester examined at search position k (k=0 is last+1).
  logic [IDX_W-1:0]          cand [NREQ];
  logic [NREQ-1:0]           hit;
  logic [NREQ:0]             taken;
  logic [NREQ:0][IDX_W-1:0]  idx_acc;

  assign taken[0]   = 1'b0;
  assign idx_acc[0] = '0;

  // Priority chain: a candidate hits only if nothing earlier in the search did.
  // Because hit is one-hot, OR-accumulating the hit index yields the winner.
  for (genvar gi = 0; gi < NREQ; gi++) begin : g_chain
    assign cand[gi]        = IDX_W'(rr_wrap(int'(last) + gi + 1, NREQ));
    assign hit[gi]         = req[cand[gi]] & ~taken[gi];
    assign taken[gi+1]     = taken[gi] | req[cand[gi]];
    assign idx_acc[gi+1]   = idx_acc[gi] | (hit[gi] ? cand[gi] : '0);
  end

  assign found  = taken[NREQ];
  assign idx    = idx_acc[NREQ];
  assign onehot = found ? (NREQ'(1) << idx) : '0;

endmodule

// File: rtl/prng_arbiter.sv
// Time-shares one PRNG between NREQ requesters as exclusive sessions
// (grant, reseed with own seed, consume words, release). Keystream is only
// ever routed to the requester whose seed produced it.
module prng_arbiter
  import prng_arb_pkg::*;
#(
  parameter int NREQ           = ARB_NREQ,
  parameter int SEED_W         = ARB_SEED_W,
  parameter int DATA_W         = ARB_DATA_W,
  parameter int REQUIRE_RESEED = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [NREQ-1:0]        req,
  input  logic [NREQ*SEED_W-1:0] seed,
  input  logic [NREQ-1:0]        reseed,
  input  logic [NREQ-1:0]        rdi_ready,
  output logic [NREQ-1:0]        gnt,
  output logic [NREQ-1:0]        reseed_ack,
  output logic [NREQ-1:0]        rdi_valid,
  output logic [DATA_W-1:0]      rdi_data,
  output logic [WORDS_W-1:0]     words,
  output logic                   busy,
  output logic [SEED_W-1:0]      prng_seed,
  output logic                   prng_reseed,
  output logic                   prng_rdi_ready,
  input  logic                   prng_reseed_ack,
  input  logic                   prng_rdi_valid,
  input  logic [DATA_W-1:0]      prng_rdi_data
);

  localparam int IDX_W = $clog2(NREQ);

  arb_state_t        state, state_next;
  logic [IDX_W-1:0]  owner, last;
  logic [SEED_W-1:0] shadow;
  logic [SEED_W-1:0] seed_arr [NREQ];

  logic [NREQ-1:0]   pick_onehot;
  logic [IDX_W-1:0]  pick_idx;
  logic              pick_found;

  logic own_req, own_reseed, own_ready, handshake;

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_seed
    assign seed_arr[gi] = seed[gi*SEED_W +: SEED_W];
  end

  prng_rr_pick #(.NREQ(NREQ), .IDX_W(IDX_W)) u_pick (
    .req    (req),
    .last   (last),
    .onehot (pick_onehot),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  assign own_req    = req[owner];
  assign own_reseed = reseed[owner];
  assign own_ready  = rdi_ready[owner];
  assign handshake  = prng_rdi_valid & prng_rdi_ready;
  assign busy       = (state != IDLE);
  assign rdi_data   = prng_rdi_data;

  // Next-state and PRNG/requester routing; everything defaults to silent.
  always_comb begin
    state_next     = state;
    prng_seed      = '0;
    prng_reseed    = 1'b0;
    prng_rdi_ready = 1'b0;
    reseed_ack     = '0;
    rdi_valid      = '0;
    case (state)
      IDLE: begin
        if (pick_found)
          state_next = (REQUIRE_RESEED != 0) ? WAIT_SEED : STREAM;
      end
      WAIT_SEED, STREAM: begin
        prng_seed         = seed_arr[owner];
        prng_reseed       = own_reseed;
        reseed_ack[owner] = prng_reseed_ack;
        // Data is frozen while a reseed is in flight so no word from the
        // old key state leaks after the owner asked for a new one.
        if (state == STREAM) begin
          prng_rdi_ready   = own_ready & ~own_reseed;
          rdi_valid[owner] = prng_rdi_valid & ~own_reseed;
        end
        if (!own_req) begin
          // An ack arriving in the same cycle completes the reseed, so
          // there is nothing left to drain.
          state_next = (own_reseed && !prng_reseed_ack) ? DRAIN : IDLE;
        end else if (state == WAIT_SEED && own_reseed && prng_reseed_ack) begin
          state_next = STREAM;
        end
      end
      DRAIN: begin
        // Finish the abandoned reseed on the PRNG with the seed it started.
        prng_reseed = 1'b1;
        prng_seed   = shadow;
        if (prng_reseed_ack)
          state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  // Session registers: state, grant/owner, round-robin pointer, word count, shadow seed.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= IDLE;
      gnt    <= '0;
      owner  <= '0;
      last   <= IDX_W'(NREQ - 1);
      words  <= '0;
      shadow <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (pick_found) begin
            gnt   <= pick_onehot;
            owner <= pick_idx;
            words <= '0;
          end
        end
        WAIT_SEED, STREAM: begin
          if (own_reseed)
            shadow <= seed_arr[owner];
          if (handshake && words != WORDS_MAX)
            words <= words + WORDS_W'(1);
          if (state_next == IDLE || state_next == DRAIN) begin
            gnt  <= '0;
            last <= owner;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prng_arbiter.sv
// Directed-sequence bench with randomized seeds/data for prng_arbiter.
// Expected grants come from a round-robin model; expected word counts from
// counting handshakes the bench itself drives.
module tb_prng_arbiter;
  import prng_arb_pkg::*;

  localparam int N  = 3;
  localparam int SW = 256;
  localparam int DW = 128;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT a: reseed required
  logic [N-1:0]    a_req, a_reseed, a_rdi_ready, a_gnt, a_reseed_ack, a_rdi_valid;
  logic [N*SW-1:0] a_seed;
  logic [DW-1:0]   a_rdi_data, a_prng_rdi_data;
  logic [15:0]     a_words;
  logic            a_busy, a_prng_reseed, a_prng_rdi_ready, a_prng_reseed_ack, a_prng_rdi_valid;
  logic [SW-1:0]   a_prng_seed;

  // DUT b: streams without reseed
  logic [N-1:0]    b_req, b_reseed, b_rdi_ready, b_gnt, b_reseed_ack, b_rdi_valid;
  logic [N*SW-1:0] b_seed;
  logic [DW-1:0]   b_rdi_data, b_prng_rdi_data;
  logic [15:0]     b_words;
  logic            b_busy, b_prng_reseed, b_prng_rdi_ready, b_prng_reseed_ack, b_prng_rdi_valid;
  logic [SW-1:0]   b_prng_seed;

  prng_arbiter #(.NREQ(N), .SEED_W(SW), .DATA_W(DW), .REQUIRE_RESEED(1)) u_a (
    .clk(clk), .rst(rst), .req(a_req), .seed(a_seed), .reseed(a_reseed),
    .rdi_ready(a_rdi_ready), .gnt(a_gnt), .reseed_ack(a_reseed_ack),
    .rdi_valid(a_rdi_valid), .rdi_data(a_rdi_data), .words(a_words), .busy(a_busy),
    .prng_seed(a_prng_seed), .prng_reseed(a_prng_reseed), .prng_rdi_ready(a_prng_rdi_ready),
    .prng_reseed_ack(a_prng_reseed_ack), .prng_rdi_valid(a_prng_rdi_valid),
    .prng_rdi_data(a_prng_rdi_data)
  );

  prng_arbiter #(.NREQ(N), .SEED_W(SW), .DATA_W(DW), .REQUIRE_RESEED(0)) u_b (
    .clk(clk), .rst(rst), .req(b_req), .seed(b_seed), .reseed(b_reseed),
    .rdi_ready(b_rdi_ready), .gnt(b_gnt), .reseed_ack(b_reseed_ack),
    .rdi_valid(b_rdi_valid), .rdi_data(b_rdi_data), .words(b_words), .busy(b_busy),
    .prng_seed(b_prng_seed), .prng_reseed(b_prng_reseed), .prng_rdi_ready(b_prng_rdi_ready),
    .prng_reseed_ack(b_prng_reseed_ack), .prng_rdi_valid(b_prng_rdi_valid),
    .prng_rdi_data(b_prng_rdi_data)
  );

  int n_cmp = 0;
  int n_bad = 0;

  logic [SW-1:0] sd [N];
  int ow, exp_last, mw, d, v;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Round-robin reference: first requester at or after last+1, wrapping.
  function automatic int rr_next(input int last_o, input logic [N-1:0] r);
    for (int k = 1; k <= N; k++) begin
      int c;
      c = (last_o + k) % N;
      if (((r >> c) & N'(1)) != '0) return c;
    end
    return -1;
  endfunction

  function automatic logic [DW-1:0] rnd_data();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    #100000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < N; i++) begin
      sd[i] = '0;
      for (int w = 0; w < SW / 32; w++) sd[i] = {sd[i][SW-33:0], 32'($urandom)};
    end
    a_seed = {sd[2], sd[1], sd[0]};
    b_seed = {sd[2], sd[1], sd[0]};
    a_req = '0; a_reseed = '0; a_rdi_ready = '0;
    a_prng_reseed_ack = 1'b0; a_prng_rdi_valid = 1'b0; a_prng_rdi_data = '0;
    b_req = '0; b_reseed = '0; b_rdi_ready = '0;
    b_prng_reseed_ack = 1'b0; b_prng_rdi_valid = 1'b0; b_prng_rdi_data = '0;
    exp_last = N - 1;

    // ---- reset values
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_gnt", 256'(a_gnt), 256'(0));
    chk("rst_words", 256'(a_words), 256'(0));
    chk("rst_busy", 256'(a_busy), 256'(0));
    chk("rst_pseed", 256'(a_prng_seed), 256'(0));
    chk("rst_preseed", 256'(a_prng_reseed), 256'(0));
    chk("rst_pready", 256'(a_prng_rdi_ready), 256'(0));
    chk("rst_b_gnt", 256'(b_gnt), 256'(0));
    #2 rst = 1'b0;

    // ---- T1: single owner, data withheld until reseed ack, then 4 handshakes
    a_req = 3'b001;
    ow = rr_next(exp_last, a_req);
    tick();
    chk("t1_gnt", 256'(a_gnt), 256'(1 << ow));
    a_prng_rdi_valid = 1'b1; a_rdi_ready = 3'b001; a_prng_rdi_data = rnd_data();
    #1;
    chk("t1_noval", 256'(a_rdi_valid), 256'(0));
    chk("t1_noready", 256'(a_prng_rdi_ready), 256'(0));
    chk("t1_seed", 256'(a_prng_seed), 256'(sd[2'(ow)]));
    chk("t1_data", 256'(a_rdi_data), 256'(a_prng_rdi_data));
    a_reseed = 3'b001;
    d = $urandom_range(1, 3);
    for (int i = 0; i < d; i++) begin
      tick();
      chk("t1_wait_val", 256'(a_rdi_valid), 256'(0));
      chk("t1_wait_preseed", 256'(a_prng_reseed), 256'(1));
    end
    a_prng_reseed_ack = 1'b1;
    #1;
    chk("t1_ack", 256'(a_reseed_ack), 256'(3'b001));
    tick();
    a_reseed = '0; a_prng_reseed_ack = 1'b0;
    mw = 0;
    for (int it = 0; it < 64 && mw < 4; it++) begin
      v = int'($urandom_range(0, 1));
      a_prng_rdi_valid = (v != 0);
      a_prng_rdi_data = rnd_data();
      #1;
      chk("t1_val", 256'(a_rdi_valid), 256'((v != 0) ? 1 : 0));
      chk("t1_rdy", 256'(a_prng_rdi_ready), 256'(1));
      tick();
      if (v != 0) mw++;
    end
    a_prng_rdi_valid = 1'b0;
    chk("t1_words", 256'(a_words), 256'(mw));
    a_req = '0; a_rdi_ready = '0;
    tick();
    chk("t1_rel_busy", 256'(a_busy), 256'(0));
    chk("t1_rel_gnt", 256'(a_gnt), 256'(0));
    chk("t1_rel_pseed", 256'(a_prng_seed), 256'(0));
    exp_last = ow;

    // ---- T2: all requesting, each owner reseeds, takes two words, releases
    for (int s = 0; s < 4; s++) begin
      a_req = 3'b111;
      ow = rr_next(exp_last, a_req);
      tick();
      chk("t2_gnt", 256'(a_gnt), 256'(1 << ow));
      a_reseed = N'(1 << ow) | (N'($urandom) & ~N'(1 << ow));
      #1;
      chk("t2_seed", 256'(a_prng_seed), 256'(sd[2'(ow)]));
      a_prng_reseed_ack = 1'b1;
      #1;
      chk("t2_ack", 256'(a_reseed_ack), 256'(1 << ow));
      tick();
      a_reseed = N'($urandom) & ~N'(1 << ow);
      a_prng_reseed_ack = 1'b0;
      a_prng_rdi_valid = 1'b1;
      a_rdi_ready = N'(1 << ow) | N'($urandom);
      #1;
      chk("t2_nonowner_reseed", 256'(a_prng_reseed), 256'(0));
      chk("t2_val", 256'(a_rdi_valid), 256'(1 << ow));
      tick();
      tick();
      chk("t2_words", 256'(a_words), 256'(2));
      a_prng_rdi_valid = 1'b0; a_reseed = '0; a_rdi_ready = '0;
      a_req = 3'b111 & ~N'(1 << ow);
      tick();
      chk("t2_idle_busy", 256'(a_busy), 256'(0));
      chk("t2_idle_gnt", 256'(a_gnt), 256'(0));
      exp_last = ow;
    end

    // ---- T3: owner drops req with reseed pending -> drain
    a_req = 3'b010;
    ow = rr_next(exp_last, a_req);
    tick();
    chk("t3_gnt", 256'(a_gnt), 256'(1 << ow));
    a_reseed = 3'b010;
    #1;
    chk("t3_seed", 256'(a_prng_seed), 256'(sd[1]));
    tick();
    a_req = '0;
    tick();
    chk("t3_busy", 256'(a_busy), 256'(1));
    chk("t3_preseed", 256'(a_prng_reseed), 256'(1));
    chk("t3_pseed", 256'(a_prng_seed), 256'(sd[1]));
    a_reseed = '0;
    a_prng_rdi_valid = 1'b1;
    #1;
    chk("t3_noval", 256'(a_rdi_valid), 256'(0));
    chk("t3_hold_preseed", 256'(a_prng_reseed), 256'(1));
    chk("t3_hold_pseed", 256'(a_prng_seed), 256'(sd[1]));
    tick();
    chk("t3_still_drain", 256'(a_prng_reseed), 256'(1));
    a_prng_reseed_ack = 1'b1;
    #1;
    chk("t3_noack", 256'(a_reseed_ack), 256'(0));
    tick();
    chk("t3_idle", 256'(a_busy), 256'(0));
    chk("t3_drop", 256'(a_prng_reseed), 256'(0));
    a_prng_reseed_ack = 1'b0; a_prng_rdi_valid = 1'b0;
    exp_last = ow;

    // ---- T4: reseed in the middle of streaming, late requester waits
    a_req = 3'b100;
    ow = rr_next(exp_last, a_req);
    tick();
    chk("t4_gnt", 256'(a_gnt), 256'(1 << ow));
    a_reseed = 3'b100; a_prng_reseed_ack = 1'b1;
    #1;
    tick();
    a_reseed = '0; a_prng_reseed_ack = 1'b0;
    a_prng_rdi_valid = 1'b1; a_rdi_ready = 3'b100;
    a_req = 3'b101;
    #1;
    chk("t4_rdy", 256'(a_prng_rdi_ready), 256'(1));
    tick();
    a_reseed = 3'b100;
    #1;
    chk("t4_rdy_off", 256'(a_prng_rdi_ready), 256'(0));
    chk("t4_val_off", 256'(a_rdi_valid), 256'(0));
    chk("t4_preseed", 256'(a_prng_reseed), 256'(1));
    tick();
    tick();
    chk("t4_words_hold", 256'(a_words), 256'(1));
    chk("t4_no_preempt", 256'(a_gnt), 256'(3'b100));
    a_prng_reseed_ack = 1'b1;
    #1;
    chk("t4_ack", 256'(a_reseed_ack), 256'(3'b100));
    tick();
    a_reseed = '0; a_prng_reseed_ack = 1'b0;
    #1;
    chk("t4_rdy_on", 256'(a_prng_rdi_ready), 256'(1));
    chk("t4_val_on", 256'(a_rdi_valid), 256'(3'b100));
    tick();
    chk("t4_words", 256'(a_words), 256'(2));

    // ---- T5: asynchronous reset mid-stream
    #3 rst = 1'b1;
    #1;
    chk("t5_gnt", 256'(a_gnt), 256'(0));
    chk("t5_pready", 256'(a_prng_rdi_ready), 256'(0));
    chk("t5_preseed", 256'(a_prng_reseed), 256'(0));
    chk("t5_words", 256'(a_words), 256'(0));
    chk("t5_busy", 256'(a_busy), 256'(0));
    #4 rst = 1'b0;
    a_req = '0; a_reseed = '0; a_rdi_ready = '0; a_prng_rdi_valid = 1'b0;
    exp_last = N - 1;
    tick();
    a_req = 3'b111;
    ow = rr_next(exp_last, a_req);
    tick();
    chk("t5_regrant", 256'(a_gnt), 256'(1 << ow));
    a_req = '0;
    tick();
    chk("t5_rel", 256'(a_busy), 256'(0));

    // ---- T6: no reseed required, data routed one cycle after req
    b_req = 3'b010; b_prng_rdi_valid = 1'b1; b_rdi_ready = 3'b010;
    b_prng_rdi_data = rnd_data();
    tick();
    chk("t6_gnt", 256'(b_gnt), 256'(3'b010));
    chk("t6_val", 256'(b_rdi_valid), 256'(3'b010));
    chk("t6_rdy", 256'(b_prng_rdi_ready), 256'(1));
    chk("t6_data", 256'(b_rdi_data), 256'(b_prng_rdi_data));
    tick();
    chk("t6_words", 256'(b_words), 256'(1));
    b_req = '0; b_prng_rdi_valid = 1'b0; b_rdi_ready = '0;
    tick();
    chk("t6_rel", 256'(b_busy), 256'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
